// File: rtl/ram_arbiter_if.sv
// Bus between the per-core caches, the shared-RAM arbiter and the RAM model.
// The slave modport is the arbiter's view; master is the cache/RAM side.
package ram_arbiter_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

interface ram_arbiter_if #(parameter int CPUS = 2);
    import ram_arbiter_pkg::*;

    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS-1:0][31:0]  daddr;
    logic [CPUS-1:0][31:0]  dstore;
    logic [CPUS-1:0]        iREN;
    logic [CPUS-1:0][31:0]  iaddr;
    logic [CPUS-1:0]        dwait;
    logic [CPUS-1:0]        iwait;
    logic [CPUS-1:0][31:0]  dload;
    logic [CPUS-1:0][31:0]  iload;
    logic                   ramREN;
    logic                   ramWEN;
    logic [31:0]            ramaddr;
    logic [31:0]            ramstore;
    logic [31:0]            ramload;
    ramstate_t              ramstate;

    modport slave (
        input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        output dwait, iwait, dload, iload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        input  dwait, iwait, dload, iload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares the single RAM port between CPUS dcaches and CPUS icaches: dcache priority
// with round-robin per class, and a starvation counter that forces a waiting icache in.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int CPUS       = 2,
    parameter int STARVE_MAX = 4
) (
    input logic         CLK,
    input logic         RST,
    ram_arbiter_if.slave bus
);
    localparam int         PW         = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic           own_i;      // owner class: 1 = icache, 0 = dcache
    logic [PW-1:0]  own_idx;    // owner core
    logic [PW-1:0]  dptr;
    logic [PW-1:0]  iptr;
    logic [2:0]     starve;

    // Returns {found, index} of the first set request at or after ptr, wrapping.
    function automatic logic [PW:0] rr_pick(input logic [CPUS-1:0] req, input logic [PW-1:0] ptr);
        logic [PW:0]   pick;
        logic [PW-1:0] idx;
        pick = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % CPUS);
            if (req[idx]) pick = {1'b1, idx};
        end
        return pick;
    endfunction

    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] idx);
        return (idx == PW'(CPUS - 1)) ? '0 : idx + 1'b1;
    endfunction

    logic [CPUS-1:0] dreq;
    logic [PW:0]     d_pick;
    logic [PW:0]     i_pick;
    logic            arb_valid;
    logic            arb_i;
    logic [PW-1:0]   arb_idx;

    always_comb begin
        dreq      = bus.dREN | bus.dWEN;
        d_pick    = rr_pick(dreq, dptr);
        i_pick    = rr_pick(bus.iREN, iptr);
        arb_valid = d_pick[PW] | i_pick[PW];
        arb_i     = 1'b0;
        arb_idx   = d_pick[PW-1:0];
        if (i_pick[PW] && (starve == STARVE_LIM || !d_pick[PW])) begin
            arb_i   = 1'b1;
            arb_idx = i_pick[PW-1:0];
        end
    end

    logic own_req;
    logic own_wr;
    logic active;
    logic done;

    // The RAM side follows the owner's live request so a dropped request aborts at once.
    always_comb begin
        // NOTE: every output gets a default first, so no path through this block infers a latch.
        own_req      = own_i ? bus.iREN[own_idx] : (bus.dREN[own_idx] | bus.dWEN[own_idx]);
        own_wr       = !own_i && bus.dWEN[own_idx];
        active       = (state == GRANT) && !RST && own_req;
        done         = active && (bus.ramstate == ACCESS);
        bus.ramREN   = active && !own_wr;
        bus.ramWEN   = active && own_wr;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.dwait    = '1;
        bus.iwait    = '1;
        bus.dload    = '0;
        bus.iload    = '0;
        if (active) begin
            bus.ramaddr = own_i ? bus.iaddr[own_idx] : bus.daddr[own_idx];
            if (own_wr) bus.ramstore = bus.dstore[own_idx];
        end
        if (done) begin
            if (own_i) begin
                bus.iwait[own_idx] = 1'b0;
                bus.iload[own_idx] = bus.ramload;
            end else begin
                bus.dwait[own_idx] = 1'b0;
                if (!own_wr) bus.dload[own_idx] = bus.ramload;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            own_i   <= 1'b0;
            own_idx <= '0;
            dptr    <= '0;
            iptr    <= '0;
            starve  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state   <= GRANT;
                        own_i   <= arb_i;
                        own_idx <= arb_idx;
                        if (arb_i) iptr <= rr_next(arb_idx);
                        else       dptr <= rr_next(arb_idx);
                    end
                    if (bus.iREN == '0 || arb_i) starve <= '0;
                    else if (starve != STARVE_LIM) starve <= starve + 3'd1;
                end
                GRANT: begin
                    if (!own_req || done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: expected grants are queued as requests are raised
// and checked against the RAM port and wait/load vectors at each completion pulse.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int CPUS = 2;

    typedef struct {
        bit          is_i;
        int          core;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] store;
    } exp_t;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;
    int   lat;
    exp_t q[$];

    ram_arbiter_if #(.CPUS(CPUS)) bus ();

    ram_arbiter #(.CPUS(CPUS), .STARVE_MAX(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required end before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] daddr_of(input int c);
        return 32'h0000_1000 + 32'(c) * 32'h10;
    endfunction

    function automatic logic [31:0] dstore_of(input int c);
        return 32'hA5A5_0000 + 32'(c);
    endfunction

    function automatic logic [31:0] iaddr_of(input int c);
        return 32'h0000_0040 + 32'(c) * 32'h4;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_tx(input bit is_i, input int core, input bit wr);
        exp_t e;
        e.is_i  = is_i;
        e.core  = core;
        e.wr    = wr;
        e.addr  = is_i ? iaddr_of(core) : daddr_of(core);
        e.store = dstore_of(core);
        q.push_back(e);
    endtask

    task automatic drop_all();
        bus.dREN = '0;
        bus.dWEN = '0;
        bus.iREN = '0;
    endtask

    task automatic do_reset();
        drop_all();
        bus.ramstate = FREE;
        bus.ramload  = '0;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        while (!(bus.ramREN || bus.ramWEN) && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
    endtask

    // Serves one grant: BUSY then ERROR cycles, then ACCESS returning load.
    task automatic complete_one(input string tag, input int busy_n, input int err_n,
                                input logic [31:0] load, input bit keep);
        exp_t                  e;
        logic [CPUS-1:0]       dw, iw;
        logic [CPUS-1:0][31:0] dl, il;
        int                    cyc;
        bit                    have;
        wait_grant(cyc);
        lat = cyc;
        check({tag, "_grant"}, 64'(bus.ramREN | bus.ramWEN), 64'(1));
        if (!(bus.ramREN || bus.ramWEN)) return;
        for (int b = 0; b < busy_n; b++) begin
            bus.ramstate = BUSY; #1;
            check({tag, "_busy_wait"}, 64'({bus.dwait, bus.iwait}), 64'(4'hF));
            @(posedge CLK); #1;
        end
        for (int r = 0; r < err_n; r++) begin
            bus.ramstate = ERROR; #1;
            check({tag, "_err_wait"}, 64'({bus.dwait, bus.iwait}), 64'(4'hF));
            check({tag, "_err_retry"}, 64'(bus.ramREN | bus.ramWEN), 64'(1));
            @(posedge CLK); #1;
        end
        bus.ramstate = ACCESS;
        bus.ramload  = load;
        #1;
        have = (q.size() != 0);
        check({tag, "_sb_nonempty"}, 64'(have), 64'(1));
        if (have) begin
            e  = q.pop_front();
            dw = '1; iw = '1; dl = '0; il = '0;
            if (e.is_i) begin
                iw[e.core] = 1'b0;
                il[e.core] = load;
            end else begin
                dw[e.core] = 1'b0;
                if (!e.wr) dl[e.core] = load;
            end
            check({tag, "_addr"},  64'(bus.ramaddr), 64'(e.addr));
            check({tag, "_wen"},   64'(bus.ramWEN),  64'(e.wr));
            check({tag, "_ren"},   64'(bus.ramREN),  64'(!e.wr));
            if (e.wr) check({tag, "_store"}, 64'(bus.ramstore), 64'(e.store));
            check({tag, "_dwait"}, 64'(bus.dwait), 64'(dw));
            check({tag, "_iwait"}, 64'(bus.iwait), 64'(iw));
            check({tag, "_dload"}, 64'(bus.dload), 64'(dl));
            check({tag, "_iload"}, 64'(bus.iload), 64'(il));
        end
        @(posedge CLK); #1;
        bus.ramstate = FREE;
        bus.ramload  = '0;
        #1;
        check({tag, "_bubble_wait"}, 64'({bus.dwait, bus.iwait}), 64'(4'hF));
        check({tag, "_bubble_en"},   64'({bus.ramREN, bus.ramWEN}), 64'(0));
        if (!keep && have) begin
            if (e.is_i) bus.iREN[e.core] = 1'b0;
            else begin
                bus.dREN[e.core] = 1'b0;
                bus.dWEN[e.core] = 1'b0;
            end
        end
    endtask

    initial begin
        int cyc;
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        bus.ramstate = FREE;
        bus.ramload  = '0;
        for (int c = 0; c < CPUS; c++) begin
            bus.daddr[c]  = daddr_of(c);
            bus.dstore[c] = dstore_of(c);
            bus.iaddr[c]  = iaddr_of(c);
        end

        // T1: reset held two cycles with every request raised.
        bus.dREN = '1; bus.dWEN = '1; bus.iREN = '1;
        for (int r = 0; r < 2; r++) begin
            @(posedge CLK); #1;
            check("t1_rst_wait", 64'({bus.dwait, bus.iwait}), 64'(4'hF));
            check("t1_rst_en",   64'({bus.ramREN, bus.ramWEN}), 64'(0));
            check("t1_rst_load", 64'(|{bus.dload, bus.iload}), 64'(0));
        end
        RST = 1'b0; #1;
        check("t1_idle_en",   64'({bus.ramREN, bus.ramWEN}), 64'(0));
        check("t1_idle_wait", 64'({bus.dwait, bus.iwait}), 64'(4'hF));
        drop_all();
        @(posedge CLK); #1;
        check("t1_quiet_en", 64'({bus.ramREN, bus.ramWEN}), 64'(0));

        // T2: single icache read, two BUSY cycles first.
        do_reset();
        bus.iREN[0] = 1'b1;
        expect_tx(1'b1, 0, 1'b0);
        complete_one("t2", 2, 0, 32'hDEAD_BEEF, 1'b0);
        check("t2_latency", 64'(lat), 64'(1));

        // T3: dcache wins over both icaches, then icaches round-robin.
        do_reset();
        bus.dREN[0] = 1'b1;
        bus.iREN    = 2'b11;
        expect_tx(1'b0, 0, 1'b0);
        expect_tx(1'b1, 0, 1'b0);
        expect_tx(1'b1, 1, 1'b0);
        complete_one("t3_d0", 0, 0, 32'h3000_0000, 1'b0);
        complete_one("t3_i0", 1, 0, 32'h3000_0001, 1'b0);
        complete_one("t3_i1", 0, 0, 32'h3000_0002, 1'b0);

        // T4: both dcaches writing continuously alternate.
        do_reset();
        bus.dWEN = 2'b11;
        expect_tx(1'b0, 0, 1'b1);
        expect_tx(1'b0, 1, 1'b1);
        expect_tx(1'b0, 0, 1'b1);
        complete_one("t4_w0", 0, 0, 32'h0, 1'b1);
        complete_one("t4_w1", 0, 0, 32'h0, 1'b1);
        complete_one("t4_w0b", 0, 0, 32'h0, 1'b1);
        drop_all();

        // T5: icache0 forced in after four dcache grants, then dcaches resume.
        do_reset();
        bus.dREN = 2'b11;
        bus.iREN = 2'b01;
        expect_tx(1'b0, 0, 1'b0);
        expect_tx(1'b0, 1, 1'b0);
        expect_tx(1'b0, 0, 1'b0);
        expect_tx(1'b0, 1, 1'b0);
        expect_tx(1'b1, 0, 1'b0);
        expect_tx(1'b0, 0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            complete_one($sformatf("t5_g%0d", k), 0, 0, 32'h5000_0000 + 32'(k), 1'b1);
        end
        drop_all();

        // T6: owner drops its request mid-grant, then an ERROR-retried write.
        do_reset();
        bus.dREN[1] = 1'b1;
        wait_grant(cyc);
        check("t6_grant", 64'(bus.ramREN), 64'(1));
        check("t6_grant_addr", 64'(bus.ramaddr), 64'(daddr_of(1)));
        bus.dREN[1]  = 1'b0;
        bus.ramstate = ACCESS;
        #1;
        check("t6_abort_en",   64'({bus.ramREN, bus.ramWEN}), 64'(0));
        check("t6_abort_wait", 64'(bus.dwait), 64'(2'b11));
        @(posedge CLK); #1;
        bus.ramstate = FREE;
        #1;
        check("t6_idle_en",   64'({bus.ramREN, bus.ramWEN}), 64'(0));
        check("t6_idle_wait", 64'(bus.dwait), 64'(2'b11));
        bus.dWEN[0] = 1'b1;
        expect_tx(1'b0, 0, 1'b1);
        complete_one("t6_err", 0, 3, 32'h0, 1'b0);

        // T7: reset during a grant with the RAM reporting ACCESS.
        do_reset();
        bus.dREN[0] = 1'b1;
        wait_grant(cyc);
        check("t7_grant", 64'(bus.ramREN), 64'(1));
        RST = 1'b1;
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h7777_7777;
        #1;
        check("t7_rst_wait", 64'(bus.dwait), 64'(2'b11));
        check("t7_rst_load", 64'(bus.dload), 64'(0));
        check("t7_rst_en",   64'({bus.ramREN, bus.ramWEN}), 64'(0));
        @(posedge CLK); #1;
        RST = 1'b0;
        drop_all();
        bus.ramstate = FREE;
        bus.ramload  = '0;
        @(posedge CLK); #1;
        check("t7_after_en",   64'({bus.ramREN, bus.ramWEN}), 64'(0));
        check("t7_after_wait", 64'({bus.dwait, bus.iwait}), 64'(4'hF));
        check("sb_drained", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
